// File: rtl/decode_execute_register.sv
// Decode/Execute pipeline register: one-cycle transport of control bits and operands,
// with stall hold and flush bubble. Optional valid tracking via DECODE_EXECUTE_REGISTER_VALID_EN.
module decode_execute_register #(
    parameter int DATA_W  = 16,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic               wbs_in,
    input  logic               wme_in,
    input  logic               mm_in,
    input  logic [ALUOP_W-1:0] ALUop_in,
    input  logic               wm_in,
    input  logic               am_in,
    input  logic               ni_in,
    input  logic [DATA_W-1:0]  srcA_in,
    input  logic [DATA_W-1:0]  srcB_in,
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
    input  logic               valid_in,
    output logic               valid_out,
`endif
    output logic               wbs_out,
    output logic               wme_out,
    output logic               mm_out,
    output logic [ALUOP_W-1:0] ALUop_out,
    output logic               wm_out,
    output logic               am_out,
    output logic               ni_out,
    output logic [DATA_W-1:0]  srcA_out,
    output logic [DATA_W-1:0]  srcB_out
);

    logic               wbs_q, wbs_d;
    logic               wme_q, wme_d;
    logic               mm_q, mm_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic               wm_q, wm_d;
    logic               am_q, am_d;
    logic               ni_q, ni_d;
    logic [DATA_W-1:0]  srca_q, srca_d;
    logic [DATA_W-1:0]  srcb_q, srcb_d;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
    logic               valid_q, valid_d;
`endif

    // Flush outranks stall so a bubble can be inserted into a held stage.
    always_comb begin
        wbs_d   = wbs_q;
        wme_d   = wme_q;
        mm_d    = mm_q;
        aluop_d = aluop_q;
        wm_d    = wm_q;
        am_d    = am_q;
        ni_d    = ni_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
        valid_d = valid_q;
`endif
        if (flush) begin
            wbs_d   = 1'b0;
            wme_d   = 1'b0;
            mm_d    = 1'b0;
            aluop_d = '0;
            wm_d    = 1'b0;
            am_d    = 1'b0;
            ni_d    = 1'b0;
            srca_d  = '0;
            srcb_d  = '0;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
            valid_d = 1'b0;
`endif
        end else if (en) begin
            wbs_d   = wbs_in;
            wme_d   = wme_in;
            mm_d    = mm_in;
            aluop_d = ALUop_in;
            wm_d    = wm_in;
            am_d    = am_in;
            ni_d    = ni_in;
            srca_d  = srcA_in;
            srcb_d  = srcB_in;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
            valid_d = valid_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_q   <= 1'b0;
            wme_q   <= 1'b0;
            mm_q    <= 1'b0;
            aluop_q <= '0;
            wm_q    <= 1'b0;
            am_q    <= 1'b0;
            ni_q    <= 1'b0;
            srca_q  <= '0;
            srcb_q  <= '0;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
            valid_q <= 1'b0;
`endif
        end else begin
            wbs_q   <= wbs_d;
            wme_q   <= wme_d;
            mm_q    <= mm_d;
            aluop_q <= aluop_d;
            wm_q    <= wm_d;
            am_q    <= am_d;
            ni_q    <= ni_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
            valid_q <= valid_d;
`endif
        end
    end

    assign wbs_out   = wbs_q;
    assign wme_out   = wme_q;
    assign mm_out    = mm_q;
    assign ALUop_out = aluop_q;
    assign wm_out    = wm_q;
    assign am_out    = am_q;
    assign ni_out    = ni_q;
    assign srcA_out  = srca_q;
    assign srcB_out  = srcb_q;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
    assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_decode_execute_register.sv
// Scoreboard bench for decode_execute_register: directed vectors push expected outputs,
// a monitor pops and compares at each falling edge or on an explicit mid-cycle check.
module tb_decode_execute_register;

    typedef struct packed {
        logic        wbs;
        logic        wme;
        logic        mm;
        logic [2:0]  alu;
        logic        wm;
        logic        am;
        logic        ni;
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
    } fields_t;

    typedef struct {
        fields_t exp;
        string   name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, en, flush;
    logic wbs_in, wme_in, mm_in, wm_in, am_in, ni_in;
    logic [2:0]  alu_in;
    logic [15:0] srca_in, srcb_in;
    logic wbs_o, wme_o, mm_o, wm_o, am_o, ni_o;
    logic [2:0]  alu_o;
    logic [15:0] srca_o, srcb_o;
    logic valid_in_s;
    logic valid_o;
    fields_t act;

    exp_t q[$];
    event chk_ev;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decode_execute_register #(.DATA_W(16), .ALUOP_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .wbs_in   (wbs_in),
        .wme_in   (wme_in),
        .mm_in    (mm_in),
        .ALUop_in (alu_in),
        .wm_in    (wm_in),
        .am_in    (am_in),
        .ni_in    (ni_in),
        .srcA_in  (srca_in),
        .srcB_in  (srcb_in),
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
        .valid_in (valid_in_s),
        .valid_out(valid_o),
`endif
        .wbs_out  (wbs_o),
        .wme_out  (wme_o),
        .mm_out   (mm_o),
        .ALUop_out(alu_o),
        .wm_out   (wm_o),
        .am_out   (am_o),
        .ni_out   (ni_o),
        .srcA_out (srca_o),
        .srcB_out (srcb_o)
    );

`ifndef DECODE_EXECUTE_REGISTER_VALID_EN
    assign valid_o = 1'b0;
`endif

    assign act = '{wbs: wbs_o, wme: wme_o, mm: mm_o, alu: alu_o, wm: wm_o,
                   am: am_o, ni: ni_o, a: srca_o, b: srcb_o, v: valid_o};

    function automatic fields_t pk(input logic wbs, input logic wme, input logic mm,
                                   input logic [2:0] alu, input logic wm, input logic am,
                                   input logic ni, input logic [15:0] a, input logic [15:0] b,
                                   input logic v);
        fields_t f;
        f.wbs = wbs; f.wme = wme; f.mm = mm; f.alu = alu; f.wm = wm;
        f.am = am; f.ni = ni; f.a = a; f.b = b;
`ifdef DECODE_EXECUTE_REGISTER_VALID_EN
        f.v = v;
`else
        f.v = 1'b0;
`endif
        return f;
    endfunction

    task automatic drive(input fields_t f, input logic en_v, input logic fl_v);
        wbs_in = f.wbs; wme_in = f.wme; mm_in = f.mm; alu_in = f.alu; wm_in = f.wm;
        am_in = f.am; ni_in = f.ni; srca_in = f.a; srcb_in = f.b; valid_in_s = f.v;
        en = en_v; flush = fl_v;
    endtask

    task automatic push(input fields_t e, input string nm);
        exp_t x;
        x.exp = e;
        x.name = nm;
        q.push_back(x);
    endtask

    // Expected value for the outputs after the next rising edge.
    task automatic edge_push(input fields_t e, input string nm);
        @(posedge clk);
        #1;
        push(e, nm);
    endtask

    task automatic now_push(input fields_t e, input string nm);
        push(e, nm);
        ->chk_ev;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() != 0) begin
                x = q.pop_front();
                total++;
                if (act === x.exp)
                    passed++;
                else
                    $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
            end
        end
    end

    initial begin : stim
        fields_t zero, ones, c1, c2, ld, st_in, ld2, all1;
        zero  = '0;
        ones  = pk(1, 1, 1, 3'b111, 1, 1, 1, 16'hFFFF, 16'hFFFF, 1);
        c1    = pk(1, 0, 1, 3'b001, 1, 1, 1, 16'h0006, 16'h0007, 1);
        c2    = pk(0, 1, 0, 3'b010, 0, 0, 0, 16'h0001, 16'h0005, 1);
        ld    = pk(0, 0, 0, 3'b101, 0, 0, 0, 16'h1234, 16'h00AB, 0);
        st_in = pk(1, 1, 1, 3'b111, 1, 1, 1, 16'hFFFF, 16'hFFFF, 1);
        ld2   = pk(0, 1, 1, 3'b110, 0, 1, 0, 16'hBEEF, 16'h0F0F, 1);
        all1  = pk(1, 1, 1, 3'b111, 1, 1, 1, 16'hFFFF, 16'h8001, 1);

        rst_n = 1'b0;
        drive(ones, 1'b1, 1'b0);
        edge_push(zero, "reset_hold_0");
        edge_push(zero, "reset_hold_1");
        #1 rst_n = 1'b1;
        #1 now_push(zero, "after_release_pre_edge");

        drive(c1, 1'b1, 1'b0);
        edge_push(c1, "capture1");
        drive(c2, 1'b1, 1'b0);
        now_push(c1, "capture2_pre_edge");
        edge_push(c2, "capture2");

        drive(ld, 1'b1, 1'b0);
        edge_push(ld, "stall_load");
        drive(st_in, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) edge_push(ld, "stall_hold");

        drive(ones, 1'b0, 1'b1);
        edge_push(zero, "flush_during_stall");
        drive(ld2, 1'b1, 1'b0);
        edge_push(ld2, "load_after_flush");
        drive(ones, 1'b1, 1'b1);
        edge_push(zero, "flush_with_en");

        drive(all1, 1'b1, 1'b0);
        edge_push(all1, "load_all_ones");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 now_push(zero, "async_reset_mid_cycle");
        edge_push(zero, "reset_held_at_edge");
        #1 rst_n = 1'b1;
        drive(c1, 1'b1, 1'b0);
        edge_push(c1, "first_capture_after_reset");

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
